imm_extend_pipe: RTL and testbench

//   Parametrised, pipelined immediate generator for the decode stage.

---
 rtl/imm_extend_pipe.sv | 181 ++++++++++++++++++
 tb/tb_imm_extend_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Decode-stage immediate generator. Decodes the RV32/RV64 immediate
//   formats (I/S/B/J/U/shamt) from a raw instruction word and sign-extends
//   the result to XLEN. The result sits behind a two-entry skid buffer
//   (main + skid register).
//
//   Optional feature macro: IMM_EXTEND_RVC_EN
//     defined   : codes 110 (CI) and 111 (CJ) decode compressed immediates
//     undefined : codes 110/111 are reserved (out_imm = 0, out_err = 1) and
//                 no compressed decode logic exists
//
//   Handshake (both sides):
//     - A beat moves only on a clock edge where valid && ready are both high.
//     - A producer holding valid high keeps its payload stable until it moves.
//     - in_ready depends only on the skid register and reset, never on
//       out_ready, so there is no combinational ready path through the block.
//     - out_* payload is held while out_valid && !out_ready.
//
//   Parameters: XLEN (32 or 64), TAG_W (side-band tag width).

module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_immc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // Immediate format select codes
    localparam logic [2:0] FMT_I     = 3'b000;
    localparam logic [2:0] FMT_S     = 3'b001;
    localparam logic [2:0] FMT_B     = 3'b010;
    localparam logic [2:0] FMT_J     = 3'b011;
    localparam logic [2:0] FMT_U     = 3'b100;
    localparam logic [2:0] FMT_SHAMT = 3'b101;
`ifdef IMM_EXTEND_RVC_EN
    localparam logic [2:0] FMT_CI    = 3'b110;
    localparam logic [2:0] FMT_CJ    = 3'b111;
`endif

    // Sign bit shared by all 32-bit formats
    logic sgn;
    assign sgn = in_instr[31];

    // Decoded value. Every format fits in 32 bits already sign- or
    // zero-extended, so widening to XLEN is a plain sign extension of ext32
    // (shamt has bit 31 clear, so it widens with zeros).
    logic [31:0]     ext32;
    logic            dec_err;
    logic [XLEN-1:0] dec_imm;

    // Opcode/low bits never contribute to an immediate in the default build
    logic unused_instr_bits;
    assign unused_instr_bits = ^in_instr[6:0];

    // Combinational format decode on the input side
    always_comb begin
        ext32   = '0;
        dec_err = 1'b0;
        case (in_immc)
            FMT_I: begin
                ext32 = {{20{sgn}}, in_instr[31:20]};
            end
            FMT_S: begin
                ext32 = {{20{sgn}}, in_instr[31:25], in_instr[11:7]};
            end
            FMT_B: begin
                ext32 = {{19{sgn}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            FMT_J: begin
                ext32 = {{11{sgn}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            FMT_U: begin
                ext32 = {in_instr[31:12], 12'b0};
            end
            FMT_SHAMT: begin
                // RV64 shifts use a 6-bit amount, RV32 a 5-bit one
                if (XLEN == 64) begin
                    ext32 = {26'b0, in_instr[25:20]};
                end else begin
                    ext32 = {27'b0, in_instr[24:20]};
                end
            end
`ifdef IMM_EXTEND_RVC_EN
            FMT_CI: begin
                // c.addi / c.li: 6-bit signed immediate
                ext32 = {{26{in_instr[12]}}, in_instr[12], in_instr[6:2]};
            end
            FMT_CJ: begin
                // c.j / c.jal: imm[11|10|9:8|7|6|5|4|3:1|0]
                ext32 = {{20{in_instr[12]}}, in_instr[12], in_instr[8],
                         in_instr[10:9], in_instr[6], in_instr[7],
                         in_instr[2], in_instr[11], in_instr[5:3], 1'b0};
            end
`endif
            default: begin
                // Reserved code: report it and drive a zero immediate
                ext32   = '0;
                dec_err = 1'b1;
            end
        endcase
    end

    // Widen the 32-bit result to the configured XLEN
    assign dec_imm = XLEN'($signed(ext32));

    // Buffer storage: main drives the outputs, skid absorbs one stalled beat
    logic             main_valid;
    logic [XLEN-1:0]  main_imm;
    logic [TAG_W-1:0] main_tag;
    logic             main_err;

    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_err;

    logic accept;
    logic main_free;

    assign in_ready  = !skid_valid && !reset;
    assign accept    = in_valid && in_ready;
    // Main can take a new beat this edge when it is empty or being popped
    assign main_free = !main_valid || out_ready;

    // Main/skid register update: refill main from skid first, else from input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_imm   <= '0;
            main_tag   <= '0;
            main_err   <= 1'b0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
            skid_err   <= 1'b0;
        end else begin
            if (main_free) begin
                if (skid_valid) begin
                    // Older stalled beat goes first; in_ready is low here
                    main_valid <= 1'b1;
                    main_imm   <= skid_imm;
                    main_tag   <= skid_tag;
                    main_err   <= skid_err;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_valid <= 1'b1;
                    main_imm   <= dec_imm;
                    main_tag   <= in_tag;
                    main_err   <= dec_err;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                // Main is stalled: park the incoming beat in the skid slot
                skid_valid <= 1'b1;
                skid_imm   <= dec_imm;
                skid_tag   <= in_tag;
                skid_err   <= dec_err;
            end
        end
    end

    assign out_valid = main_valid;
    assign out_imm   = main_imm;
    assign out_tag   = main_tag;
    assign out_err   = main_err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Drives an XLEN=32 and an XLEN=64 instance with identical input streams.
//   A queue-based model tracks the beats held by the buffer and a reference
//   decoder computes each immediate with plain arithmetic.

module tb_imm_extend_pipe;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid;
    logic [31:0] in_instr;
    logic [2:0]  in_immc;
    logic [4:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_err32;
    logic [31:0] out_imm32;
    logic [4:0]  out_tag32;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [4:0]  out_tag64;

    imm_extend_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_immc(in_immc), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_immc(in_immc), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [63:0] imm64;
        logic [31:0] imm32;
        logic [4:0]  tag;
        logic        err;
    } beat_t;

    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    bit rand_en = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder: assemble the immediate field, then sign-extend by
    // subtracting 2^w when its top bit is set.
    function automatic void ref_imm(input logic [31:0] ins, input logic [2:0] c,
                                    input bit x64, output logic [63:0] v, output logic e);
        longint raw;
        int     w;
        bit     sx;
`ifdef IMM_EXTEND_RVC_EN
        logic [11:0] off;
`endif
        raw = 0; w = 1; sx = 1; e = 0;
        case (c)
            3'd0: begin raw = longint'(ins[31:20]); w = 12; end
            3'd1: begin raw = longint'({ins[31:25], ins[11:7]}); w = 12; end
            3'd2: begin raw = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); w = 13; end
            3'd3: begin raw = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); w = 21; end
            3'd4: begin raw = longint'(ins[31:12]) * 4096; w = 32; end
            3'd5: begin raw = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]); sx = 0; end
`ifdef IMM_EXTEND_RVC_EN
            3'd6: begin raw = longint'({ins[12], ins[6:2]}); w = 6; end
            default: begin
                off = '0;
                off[11] = ins[12]; off[4] = ins[11]; off[9:8] = ins[10:9];
                off[10] = ins[8];  off[6] = ins[7];  off[7] = ins[6];
                off[3:1] = ins[5:3]; off[5] = ins[2];
                raw = longint'(off); w = 12;
            end
`else
            default: begin raw = 0; sx = 0; e = 1; end
`endif
        endcase
        if (sx && raw >= (longint'(1) << (w - 1))) raw = raw - (longint'(1) << w);
        v = raw;
    endfunction

    // Model update: the buffer is a FIFO of at most two beats
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            bit pop, acc;
            beat_t b;
            logic [63:0] v;
            logic e;
            pop = (exp_q.size() > 0) && out_ready;
            acc = in_valid && (exp_q.size() < 2);
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                ref_imm(in_instr, in_immc, 1'b1, v, e);
                b.imm64 = v;
                ref_imm(in_instr, in_immc, 1'b0, v, e);
                b.imm32 = v[31:0];
                b.tag = in_tag;
                b.err = e;
                exp_q.push_back(b);
            end
        end
    end

    // Compare process: checks both instances on every falling edge
    always @(negedge clk) begin
        chk("out_valid32", out_valid32, exp_q.size() > 0);
        chk("out_valid64", out_valid64, exp_q.size() > 0);
        chk("in_ready32", in_ready32, (exp_q.size() < 2) && !reset);
        chk("in_ready64", in_ready64, (exp_q.size() < 2) && !reset);
        if (exp_q.size() > 0) begin
            chk("imm32", out_imm32, exp_q[0].imm32);
            chk("imm64", out_imm64, exp_q[0].imm64);
            chk("tag32", out_tag32, exp_q[0].tag);
            chk("tag64", out_tag64, exp_q[0].tag);
            chk("err32", out_err32, exp_q[0].err);
            chk("err64", out_err64, exp_q[0].err);
        end
    end

    // ---------------- driver tasks ----------------
    // Holds a beat on the input until it is accepted; returns #1 after that edge
    task automatic send(input logic [31:0] ins, input logic [2:0] c, input logic [4:0] t);
        bit done;
        done = 0;
        in_instr = ins; in_immc = c; in_tag = t; in_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            if (in_ready32) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: beat tag %0d not accepted within 64 cycles", t);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Random backpressure, applied away from the driver's update slot
    initial begin
        forever begin
            @(posedge clk); #2;
            if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] v;
        logic e;
        reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_immc = '0; in_tag = '0;
        out_ready = 1'b1;

        // Pin the reference decoder with hand-computed values
        ref_imm(32'hFFF00093, 3'd0, 0, v, e); chk("pin_i", v[31:0], 32'hFFFFFFFF);
        ref_imm(32'h0020A423, 3'd1, 0, v, e); chk("pin_s", v[31:0], 32'h00000008);
        ref_imm(32'hFE000EE3, 3'd2, 0, v, e); chk("pin_b", v[31:0], 32'hFFFFFFFC);
        ref_imm(32'h123450B7, 3'd4, 0, v, e); chk("pin_u", v[31:0], 32'h12345000);
        ref_imm(32'h800000B7, 3'd4, 1, v, e); chk("pin_u64", v, 64'hFFFFFFFF80000000);
        ref_imm(32'h03F01013, 3'd5, 1, v, e); chk("pin_sh64", v, 64'h3F);
        ref_imm(32'h03F01013, 3'd5, 0, v, e); chk("pin_sh32", v, 64'h1F);
        ref_imm(32'h0000107C, 3'd6, 0, v, e);
`ifdef IMM_EXTEND_RVC_EN
        chk("pin_ci", v[31:0], 32'hFFFFFFFF); chk("pin_ci_err", e, 0);
        ref_imm(32'h00001FFC, 3'd7, 0, v, e); chk("pin_cj_neg", v[31:0], 32'hFFFFFFFE);
        ref_imm(32'h00000100, 3'd7, 0, v, e); chk("pin_cj_b10", v[31:0], 32'h00000400);
`else
        chk("pin_ci", v[31:0], 32'h0); chk("pin_ci_err", e, 1);
`endif

        // Reset state
        idle(2);
        chk("rst_valid", out_valid32, 0);
        chk("rst_ready", in_ready32, 0);
        chk("rst_imm", out_imm64, 0);
        chk("rst_tag", out_tag32, 0);
        chk("rst_err", out_err32, 0);
        reset = 1'b0;

        // 1: single I-type beat, first edge after reset release
        send(32'hFFF00093, 3'd0, 5'd1);
        chk("t1_valid", out_valid32, 1);
        chk("t1_imm", out_imm32, 32'hFFFFFFFF);
        chk("t1_err", out_err32, 0);

        // 2: back-to-back beats on consecutive cycles
        send(32'h0020A423, 3'd1, 5'd2); chk("t2_s", out_imm32, 32'h00000008);
        send(32'hFE000EE3, 3'd2, 5'd3); chk("t2_b", out_imm32, 32'hFFFFFFFC);
        send(32'h123450B7, 3'd4, 5'd4); chk("t2_u", out_imm32, 32'h12345000);

        // 3: XLEN=64 upper and shamt
        send(32'h800000B7, 3'd4, 5'd5); chk("t3_u64", out_imm64, 64'hFFFFFFFF80000000);
        send(32'h03F01013, 3'd5, 5'd6); chk("t3_sh64", out_imm64, 64'h3F);
        chk("t3_sh32", out_imm32, 32'h1F);
        idle(2);

        // 4: backpressure, two beats held, third waits
        out_ready = 1'b0;
        send(32'h00500093, 3'd0, 5'd1);
        send(32'h00700093, 3'd0, 5'd2);
        chk("t4_full", in_ready32, 0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t4_hold_imm", out_imm32, 32'h5);
            chk("t4_hold_tag", out_tag32, 5'd1);
        end
        out_ready = 1'b1;
        send(32'h00900093, 3'd0, 5'd3);
        idle(3);

        // 5: compressed CI code
        send(32'h0000107C, 3'd6, 5'd9);
`ifdef IMM_EXTEND_RVC_EN
        chk("t5_imm", out_imm32, 32'hFFFFFFFF); chk("t5_err", out_err32, 0);
`else
        chk("t5_imm", out_imm32, 32'h0); chk("t5_err", out_err32, 1);
`endif
        idle(2);

        // 6: asynchronous reset with both registers full
        out_ready = 1'b0;
        send(32'h12345037, 3'd4, 5'd10);
        send(32'h00100093, 3'd0, 5'd11);
        chk("t6_full_ready", in_ready32, 0);
        chk("t6_full_valid", out_valid32, 1);
        #3 reset = 1'b1;
        #1;
        chk("t6_rst_valid", out_valid32, 0);
        chk("t6_rst_ready", in_ready32, 0);
        chk("t6_rst_imm", out_imm32, 0);
        chk("t6_rst_tag", out_tag64, 0);
        @(posedge clk); #3 reset = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(32'hFFF00093, 3'd0, 5'd7);
        chk("t6_after_valid", out_valid32, 1);
        chk("t6_after_imm", out_imm32, 32'hFFFFFFFF);
        chk("t6_after_tag", out_tag32, 5'd7);
        idle(1);
        chk("t6_no_stale", out_valid32, 0);

        // Random traffic with random backpressure
        rand_en = 1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            send($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        end
        rand_en = 0;
        idle(1);
        out_ready = 1'b1;
        for (int n = 0; n < 50 && (out_valid32 || out_valid64); n++) idle(1);
        chk("drain32", out_valid32, 0);
        chk("drain64", out_valid64, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
